// File: rtl/csi2_tx_pkg.sv
// Shared definitions for the CSI-2 two-lane packet transmitter:
// data types, sync byte, FSM state encoding and the header ECC function.
package csi2_tx_pkg;

    localparam logic [5:0] DT_FS     = 6'h00;
    localparam logic [5:0] DT_FE     = 6'h01;
    localparam logic [5:0] DT_RAW10  = 6'h2B;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        SOT,
        HDR0,
        HDR1,
        PAYLOAD,
        CRC,
        EOT
    } tx_state_t;

    typedef enum logic [1:0] {
        PK_FS,
        PK_LINE,
        PK_FE
    } pkt_kind_t;

    // CSI-2 header ECC: six parity bits over {WC_hi, WC_lo, DI}, bits [7:6] zero.
    // Each mask selects the header bits that feed one parity bit.
    function automatic logic [7:0] csi2_ecc(input logic [23:0] hdr);
        logic [7:0] ecc;
        ecc    = 8'h00;
        ecc[0] = ^(hdr & 24'hF12CB7);
        ecc[1] = ^(hdr & 24'hF2555B);
        ecc[2] = ^(hdr & 24'h749A6D);
        ecc[3] = ^(hdr & 24'hB8E38E);
        ecc[4] = ^(hdr & 24'hDF03F0);
        ecc[5] = ^(hdr & 24'hEFFC00);
        return ecc;
    endfunction

endpackage

// File: rtl/csi2_crc16_2b.sv
// CSI-2 payload CRC16 (reflected 0x8408, init 0xFFFF, no final XOR),
// advancing two bytes per clock; data[7:0] is the earlier byte.
module csi2_crc16_2b (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] data,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc_step16(input logic [15:0] cur, input logic [15:0] din);
        logic [15:0] r;
        r = cur;
        for (int i = 0; i < 16; i++) begin
            if (r[0] ^ din[i]) begin
                r = (r >> 1) ^ 16'h8408;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    // CRC register: clear wins over enable so a new packet always starts clean.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            crc <= 16'hFFFF;
        end else if (clear) begin
            crc <= 16'hFFFF;
        end else if (enable) begin
            crc <= crc_step16(crc, data);
        end
    end

endmodule

// File: rtl/csi2_packet_tx.sv
// CSI-2 two-lane byte-level packet transmitter (FS/FE short packets and
// pixel-line long packets). Optional feature macro: CSI2_TX_FRAME_COUNT_EN
// puts a 1-based wrapping frame number in the short-packet word count.
module csi2_packet_tx
    import csi2_tx_pkg::*;
#(
    parameter int         LINE_BYTES = 1280,
    parameter logic [5:0] DATA_TYPE  = DT_RAW10,
    parameter logic [1:0] VC         = 2'd0
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        fs_req,
    input  logic        line_req,
    input  logic        fe_req,
    output logic        req_ack,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  lane0_byte,
    output logic [7:0]  lane1_byte,
    output logic        hs_valid,
    output logic        busy,
    output logic        err_underflow
);

    localparam int BEATS  = LINE_BYTES / 2;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if ((LINE_BYTES <= 0) || ((LINE_BYTES % 2) != 0)) begin : g_bad_line_bytes
            $error("csi2_packet_tx: LINE_BYTES must be even and nonzero");
        end
    endgenerate

    tx_state_t   state, state_nxt;
    pkt_kind_t   kind;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [15:0] short_wc;
    logic [BEAT_W-1:0] beat;
    logic [7:0]  ecc;
    logic        crc_clear, crc_en;
    logic [15:0] crc_data, crc;
    logic        accept;
    pkt_kind_t   accept_kind;

`ifdef CSI2_TX_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    // Frame number advances once each FE packet finishes, skipping zero on wrap.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= 16'h0001;
        end else if (state == EOT && kind == PK_FE) begin
            frame_cnt <= (frame_cnt == 16'hFFFF) ? 16'h0001 : frame_cnt + 16'h0001;
        end
    end

    assign short_wc = frame_cnt;
`else
    assign short_wc = 16'h0000;
`endif

    assign ecc  = csi2_ecc({wc, di});
    assign busy = (state != IDLE);

    // Accepted request picks the packet kind; fs beats line beats fe.
    always_comb begin
        accept      = 1'b0;
        accept_kind = PK_FS;
        if (state == IDLE && reset) begin
            if (fs_req) begin
                accept      = 1'b1;
                accept_kind = PK_FS;
            end else if (line_req) begin
                accept      = 1'b1;
                accept_kind = PK_LINE;
            end else if (fe_req) begin
                accept      = 1'b1;
                accept_kind = PK_FE;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Packet kind, payload beat counter and sticky underflow flag.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            kind          <= PK_FS;
            beat          <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (accept) begin
                kind <= accept_kind;
            end
            beat <= (state == PAYLOAD) ? beat + 1'b1 : '0;
            if (state == PAYLOAD && !pix_valid) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Header fields latched at accept; they are only observed after SOT.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            case (accept_kind)
                PK_LINE: begin
                    di <= {VC, DATA_TYPE};
                    wc <= 16'(LINE_BYTES);
                end
                PK_FE: begin
                    di <= {VC, DT_FE};
                    wc <= short_wc;
                end
                default: begin
                    di <= {VC, DT_FS};
                    wc <= short_wc;
                end
            endcase
        end
    end

    // Next state and per-state lane outputs.
    always_comb begin
        state_nxt  = state;
        req_ack    = 1'b0;
        pix_ready  = 1'b0;
        lane0_byte = 8'h00;
        lane1_byte = 8'h00;
        hs_valid   = 1'b0;
        crc_clear  = 1'b0;
        crc_en     = 1'b0;
        crc_data   = 16'h0000;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ack   = 1'b1;
                    state_nxt = SOT;
                end
            end
            SOT: begin
                hs_valid   = 1'b1;
                lane0_byte = SYNC_BYTE;
                lane1_byte = SYNC_BYTE;
                state_nxt  = HDR0;
            end
            HDR0: begin
                hs_valid   = 1'b1;
                lane0_byte = di;
                lane1_byte = wc[7:0];
                state_nxt  = HDR1;
            end
            HDR1: begin
                hs_valid   = 1'b1;
                lane0_byte = wc[15:8];
                lane1_byte = ecc;
                crc_clear  = 1'b1;
                state_nxt  = (kind == PK_LINE) ? PAYLOAD : EOT;
            end
            PAYLOAD: begin
                hs_valid = 1'b1;
                crc_en   = 1'b1;
                if (pix_valid) begin
                    pix_ready  = 1'b1;
                    lane0_byte = pix_data[7:0];
                    lane1_byte = pix_data[15:8];
                    crc_data   = pix_data;
                end
                if (beat == LAST_BEAT) begin
                    state_nxt = CRC;
                end
            end
            CRC: begin
                hs_valid   = 1'b1;
                lane0_byte = crc[7:0];
                lane1_byte = crc[15:8];
                state_nxt  = EOT;
            end
            EOT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    csi2_crc16_2b u_crc (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (crc_clear),
        .enable  (crc_en),
        .data    (crc_data),
        .crc     (crc)
    );

endmodule

// File: tb/tb_csi2_packet_tx.sv
// Self-checking bench for csi2_packet_tx: a byte-stream packet model feeds an
// expectation queue that a per-cycle compare process drains.
module tb_csi2_packet_tx;

    localparam int LB = 24;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b0;
    logic        fs_req = 1'b0, line_req = 1'b0, fe_req = 1'b0;
    logic        req_ack;
    logic [15:0] pix_data  = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  lane0_byte, lane1_byte;
    logic        hs_valid, busy, err_underflow;

    always #5 sys_clk = ~sys_clk;

    csi2_packet_tx #(.LINE_BYTES(LB), .DATA_TYPE(6'h2B), .VC(2'd0)) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .fs_req        (fs_req),
        .line_req      (line_req),
        .fe_req        (fe_req),
        .req_ack       (req_ack),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .lane0_byte    (lane0_byte),
        .lane1_byte    (lane1_byte),
        .hs_valid      (hs_valid),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] l0;
        logic [7:0] l1;
        logic       hs;
        logic       bsy;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0]  vec [LB] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                              8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                              8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    logic [15:0] fnum;
    bit          cmp_en = 1'b0;
    logic [7:0]  h0l0, h0l1, h1l0, h1l1, crc_l0, crc_l1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Header ECC: XOR of the CSI-2 syndrome code for every set header bit.
    function automatic logic [7:0] ecc_model(input logic [23:0] h);
        logic [5:0] code [24];
        logic [5:0] s;
        code = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                 6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        s = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (h[i]) s = s ^ code[i];
        end
        return {2'b00, s};
    endfunction

    function automatic logic [15:0] crc_model(input logic [7:0] b [$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[k]) begin
            for (int i = 0; i < 8; i++) begin
                c = (c[0] ^ b[k][i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b, input logic h, input logic y);
        exp_t e;
        e.l0 = a; e.l1 = b; e.hs = h; e.bsy = y;
        return e;
    endfunction

    // kind: 0=FS, 1=line, 2=FE; ub = payload beat with pix_valid low (-1: none).
    task automatic push_packet(input int kind, input int ub);
        logic [7:0]  bytes [$];
        logic [7:0]  pay [$];
        logic [5:0]  dt;
        logic [15:0] wc, c;
        logic [7:0]  di;
        dt = (kind == 0) ? 6'h00 : (kind == 1) ? 6'h2B : 6'h01;
        wc = (kind == 1) ? 16'(LB) : fnum;
        di = {2'd0, dt};
        bytes.push_back(di);
        bytes.push_back(wc[7:0]);
        bytes.push_back(wc[15:8]);
        bytes.push_back(ecc_model({wc, di}));
        if (kind == 1) begin
            for (int n = 0; n < LB; n++) pay.push_back((n / 2 == ub) ? 8'h00 : vec[n]);
            foreach (pay[k]) bytes.push_back(pay[k]);
            c = crc_model(pay);
            bytes.push_back(c[7:0]);
            bytes.push_back(c[15:8]);
        end
        exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hB8, 8'hB8, 1'b1, 1'b1));
        for (int n = 0; n < bytes.size(); n += 2) exp_q.push_back(mk(bytes[n], bytes[n+1], 1'b1, 1'b1));
        exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1));
    endtask

    // Compare process: every falling edge, DUT lanes against the model stream.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!reset) begin
            exp_q.delete();
        end else if (cmp_en) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("lane0", {24'h0, lane0_byte}, {24'h0, e.l0});
            chk("lane1", {24'h0, lane1_byte}, {24'h0, e.l1});
            chk("hs_valid", {31'h0, hs_valid}, {31'h0, e.hs});
            chk("busy", {31'h0, busy}, {31'h0, e.bsy});
        end
    end

    task automatic transact(input bit f, input bit l, input bit e, input int ub);
        int kind;
        kind = f ? 0 : (l ? 1 : 2);
        @(posedge sys_clk); #1;
        fs_req = f; line_req = l; fe_req = e;
        push_packet(kind, ub);
        #1 chk("req_ack", {31'h0, req_ack}, 32'h1);
        @(posedge sys_clk); #1;
        fs_req = 1'b0; line_req = 1'b0; fe_req = 1'b0;
        chk("req_ack_sot", {31'h0, req_ack}, 32'h0);
        @(posedge sys_clk); #1;
        h0l0 = lane0_byte; h0l1 = lane1_byte;
        @(posedge sys_clk); #1;
        h1l0 = lane0_byte; h1l1 = lane1_byte;
        if (kind == 1) begin
            for (int b = 0; b < LB / 2; b++) begin
                @(posedge sys_clk); #1;
                pix_data  = {vec[2*b+1], vec[2*b]};
                pix_valid = (b != ub);
                #1 chk("pix_ready", {31'h0, pix_ready}, {31'h0, (b != ub)});
            end
            @(posedge sys_clk); #1;
            pix_valid = 1'b0; pix_data = 16'h0000;
            crc_l0 = lane0_byte; crc_l1 = lane1_byte;
        end
        repeat (2) @(posedge sys_clk);
        #1;
`ifdef CSI2_TX_FRAME_COUNT_EN
        if (kind == 2) fnum = (fnum == 16'hFFFF) ? 16'h0001 : fnum + 16'h0001;
`endif
    endtask

    initial begin
        logic [7:0] vq [$];
`ifdef CSI2_TX_FRAME_COUNT_EN
        fnum = 16'h0001;
`else
        fnum = 16'h0000;
`endif
        foreach (vec[k]) vq.push_back(vec[k]);

        // Model pinned against hand-computed values.
        chk("ecc_lit_2b_0004", {24'h0, ecc_model(24'h00042B)}, 32'h34);
        chk("ecc_lit_fs_0001", {24'h0, ecc_model(24'h000100)}, 32'h1A);
        chk("crc_lit_vector", {16'h0, crc_model(vq)}, 32'h00F0);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_hs_valid", {31'h0, hs_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_lanes", {16'h0, lane1_byte, lane0_byte}, 32'h0);
        chk("rst_req_ack", {31'h0, req_ack}, 32'h0);
        chk("rst_pix_ready", {31'h0, pix_ready}, 32'h0);
        chk("rst_err", {31'h0, err_underflow}, 32'h0);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Frame Start
        transact(1'b1, 1'b0, 1'b0, -1);
        chk("fs_hdr0", {16'h0, h0l0, h0l1}, 32'h0000);
`ifdef CSI2_TX_FRAME_COUNT_EN
        chk("fs_hdr1_wc1", {16'h0, h1l0, h1l1}, 32'h001A);
        chk("fs_wc_lo_1", {24'h0, h0l1}, 32'h01);
`else
        chk("fs_hdr1", {16'h0, h1l0, h1l1}, 32'h0000);
`endif

        // Long packet, full payload
        transact(1'b0, 1'b1, 1'b0, -1);
        chk("line_hdr0", {16'h0, h0l0, h0l1}, 32'h2B18);
        chk("line_crc_lanes", {16'h0, crc_l0, crc_l1}, 32'hF000);
        chk("no_underflow", {31'h0, err_underflow}, 32'h0);

        // Frame End, then Frame Start again
        transact(1'b0, 1'b0, 1'b1, -1);
        transact(1'b1, 1'b0, 1'b0, -1);
`ifdef CSI2_TX_FRAME_COUNT_EN
        chk("fs2_wc_lo_2", {24'h0, h0l1}, 32'h02);
`endif

        // Simultaneous requests: FS wins, others dropped
        transact(1'b1, 1'b1, 1'b1, -1);
        repeat (3) @(posedge sys_clk);
        #1 chk("dropped_idle", {31'h0, busy}, 32'h0);

        // Underflow on beat 5
        transact(1'b0, 1'b1, 1'b0, 5);
        chk("underflow_set", {31'h0, err_underflow}, 32'h1);
        transact(1'b0, 1'b0, 1'b1, -1);
        chk("underflow_sticky", {31'h0, err_underflow}, 32'h1);

        // Reset during payload
        @(posedge sys_clk); #1;
        line_req = 1'b1;
        push_packet(1, -1);
        @(posedge sys_clk); #1;
        line_req = 1'b0;
        repeat (2) @(posedge sys_clk);
        for (int b = 0; b < 4; b++) begin
            @(posedge sys_clk); #1;
            pix_data = {vec[2*b+1], vec[2*b]};
            pix_valid = 1'b1;
        end
        chk("midpkt_hs_before", {31'h0, hs_valid}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_hs_valid", {31'h0, hs_valid}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_lanes", {16'h0, lane1_byte, lane0_byte}, 32'h0);
        chk("midrst_pix_ready", {31'h0, pix_ready}, 32'h0);
        chk("midrst_err", {31'h0, err_underflow}, 32'h0);
        pix_valid = 1'b0; pix_data = 16'h0000;
        repeat (2) @(posedge sys_clk);
        #1 reset = 1'b1;
`ifdef CSI2_TX_FRAME_COUNT_EN
        fnum = 16'h0001;
`endif
        transact(1'b1, 1'b0, 1'b0, -1);
        chk("post_rst_err", {31'h0, err_underflow}, 32'h0);

        repeat (3) @(posedge sys_clk);
        #1 chk("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
